// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing defaults and scan-axis state encoding for the display path.
// Renderers and the sync generator import these so every block agrees on one timing set.
package vga_sync_gen_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } axis_state_t;

    function automatic logic sync_level(input axis_state_t st, input logic pol);
        return (st == ST_SYNC) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_sync_gen_axis_timer.sv
// One scan axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// Used once for the horizontal axis and once for the vertical axis.
module vga_axis_timer
    import vga_sync_gen_pkg::*;
#(
    parameter int   ACTIVE   = H_ACTIVE_DEF,
    parameter int   FRONT    = H_FRONT_DEF,
    parameter int   SYNC     = H_SYNC_DEF,
    parameter int   BACK     = H_BACK_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output axis_state_t      state,
    output logic             wrap_next,
    output logic             sync,
    output logic             active,
    output logic             active_next
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(ACTIVE + FRONT - 1);
    localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(ACTIVE + FRONT + SYNC - 1);

    if (TOTAL > MAX_TOTAL || ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_timing
        $error("vga_axis_timer: each phase must be >= 1 and the total <= 1024");
    end

    logic [CNT_W-1:0] count_nxt;
    axis_state_t      state_nxt;

    assign wrap_next = (count == LAST);

    always_comb begin
        count_nxt = count;
        state_nxt = state;
        if (clear) begin
            count_nxt = LAST;
            state_nxt = ST_BACK;
        end else if (step) begin
            count_nxt = wrap_next ? '0 : count + 1'b1;
            case (state)
                ST_ACTIVE: if (count == END_ACTIVE) state_nxt = ST_FRONT;
                ST_FRONT:  if (count == END_FRONT)  state_nxt = ST_SYNC;
                ST_SYNC:   if (count == END_SYNC)   state_nxt = ST_BACK;
                ST_BACK:   if (wrap_next)           state_nxt = ST_ACTIVE;
                default:                            state_nxt = ST_BACK;
            endcase
        end
    end

    // Parent registers this with the other axis so video_on comes straight from a flop.
    assign active_next = (state_nxt == ST_ACTIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= LAST;
            state  <= ST_BACK;
            sync   <= ~SYNC_POL;
            active <= 1'b0;
        end else begin
            count  <= count_nxt;
            state  <= state_nxt;
            sync   <= sync_level(state_nxt, SYNC_POL);
            active <= active_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480 VGA timing controller: pixel-rate divider, H/V scan counters, registered
// sync, blanking and scan-position strobes, all updating on the same edge as the counters.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FRONT  = H_FRONT_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BACK   = H_BACK_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FRONT  = V_FRONT_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BACK   = V_BACK_DEF,
    parameter int   CLK_DIV  = 2,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] CounterX,
    output logic [CNT_W-1:0] CounterY,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             pix_tick,
    output logic             line_start,
    output logic             frame_start
);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be in 1..16");
    end

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]       div_cnt;
    logic             clear;
    logic             pix_step;
    logic             v_step;

    logic [CNT_W-1:0] h_count, v_count;
    axis_state_t      h_state, v_state;
    logic             h_wrap_next, v_wrap_next;
    logic             h_sync, v_sync;
    logic             h_active, v_active;
    logic             h_active_next, v_active_next;

    assign clear    = ~enable;
    assign pix_step = enable & (div_cnt == DIV_LAST);
    assign v_step   = pix_step & h_wrap_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (clear || pix_step) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    vga_axis_timer #(
        .ACTIVE   (H_ACTIVE),
        .FRONT    (H_FRONT),
        .SYNC     (H_SYNC),
        .BACK     (H_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_h_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .step        (pix_step),
        .count       (h_count),
        .state       (h_state),
        .wrap_next   (h_wrap_next),
        .sync        (h_sync),
        .active      (h_active),
        .active_next (h_active_next)
    );

    vga_axis_timer #(
        .ACTIVE   (V_ACTIVE),
        .FRONT    (V_FRONT),
        .SYNC     (V_SYNC),
        .BACK     (V_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_v_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .step        (v_step),
        .count       (v_count),
        .state       (v_state),
        .wrap_next   (v_wrap_next),
        .sync        (v_sync),
        .active      (v_active),
        .active_next (v_active_next)
    );

    assign CounterX = h_count;
    assign CounterY = v_count;
    assign hsync    = h_sync;
    assign vsync    = v_sync;

    // Strobes are computed from pre-edge wrap flags so they land with the new counter value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_on    <= h_active_next & v_active_next;
            pix_tick    <= pix_step;
            line_start  <= v_step;
            frame_start <= v_step & v_wrap_next;
        end
    end

    a_video_on: assert property (@(posedge clk) disable iff (reset)
        video_on == (h_active && v_active));
    a_h_state: assert property (@(posedge clk) disable iff (reset)
        (h_state == ST_ACTIVE) == h_active);
    a_v_state: assert property (@(posedge clk) disable iff (reset)
        (v_state == ST_ACTIVE) == v_active);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing, a reduced timing at CLK_DIV=2, and a reduced
// timing at CLK_DIV=1 with active-high sync, against a linear-scan-position reference model.
module tb_vga_sync_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, div;
        bit pol;
    } cfg_t;

    typedef struct {
        int x, y, dc;
        bit tick, ls, fs;
    } ms_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en_d = 1'b0, en_s = 1'b0, en_p = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cfg_t cd = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
    cfg_t cs = '{20, 3, 5, 4, 12, 2, 2, 3, 2, 1'b0};
    cfg_t cp = '{20, 3, 5, 4, 12, 2, 2, 3, 1, 1'b1};

    logic [9:0] dx, dy, sx, sy, px, py;
    logic dhs, dvs, dvo, dtk, dls, dfs;
    logic s_hs, s_vs, s_vo, s_tk, s_ls, s_fs;
    logic p_hs, p_vs, p_vo, p_tk, p_ls, p_fs;

    vga_sync_gen dut_d (
        .clk(clk), .reset(reset), .enable(en_d), .CounterX(dx), .CounterY(dy),
        .hsync(dhs), .vsync(dvs), .video_on(dvo), .pix_tick(dtk),
        .line_start(dls), .frame_start(dfs)
    );

    vga_sync_gen #(
        .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .reset(reset), .enable(en_s), .CounterX(sx), .CounterY(sy),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_vo), .pix_tick(s_tk),
        .line_start(s_ls), .frame_start(s_fs)
    );

    vga_sync_gen #(
        .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut_p (
        .clk(clk), .reset(reset), .enable(en_p), .CounterX(px), .CounterY(py),
        .hsync(p_hs), .vsync(p_vs), .video_on(p_vo), .pix_tick(p_tk),
        .line_start(p_ls), .frame_start(p_fs)
    );

    // ---------------- reference model: scan position as one linear index ----------------
    function automatic ms_t mreset(input cfg_t c);
        ms_t r;
        r.x = c.ha + c.hf + c.hs + c.hb - 1;
        r.y = c.va + c.vf + c.vs + c.vb - 1;
        r.dc = 0; r.tick = 0; r.ls = 0; r.fs = 0;
        return r;
    endfunction

    function automatic ms_t mstep(input cfg_t c, input ms_t s, input bit en);
        ms_t r;
        int htot, vtot, p;
        if (!en) return mreset(c);
        htot = c.ha + c.hf + c.hs + c.hb;
        vtot = c.va + c.vf + c.vs + c.vb;
        r = s;
        r.tick = 0; r.ls = 0; r.fs = 0;
        if (s.dc == c.div - 1) begin
            p = (s.y * htot + s.x + 1) % (htot * vtot);
            r.dc = 0;
            r.x = p % htot;
            r.y = p / htot;
            r.tick = 1;
            r.ls = (r.x == 0);
            r.fs = (p == 0);
        end else begin
            r.dc = s.dc + 1;
        end
        return r;
    endfunction

    function automatic logic mhs(input cfg_t c, input ms_t s);
        int lo;
        lo = c.ha + c.hf;
        return (s.x >= lo && s.x < lo + c.hs) ? c.pol : !c.pol;
    endfunction

    function automatic logic mvs(input cfg_t c, input ms_t s);
        int lo;
        lo = c.va + c.vf;
        return (s.y >= lo && s.y < lo + c.vs) ? c.pol : !c.pol;
    endfunction

    function automatic logic mvo(input cfg_t c, input ms_t s);
        return (s.x < c.ha) && (s.y < c.va);
    endfunction

    ms_t md, ms, mp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md <= mreset(cd);
            ms <= mreset(cs);
            mp <= mreset(cp);
        end else begin
            md <= mstep(cd, md, en_d);
            ms <= mstep(cs, ms, en_s);
            mp <= mstep(cp, mp, en_p);
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset;
        @(negedge clk);
        tests++;
        if (dx !== 10'd799 || dy !== 10'd524) begin
            fails++;
            $display("FAIL reset_xy got (%0d,%0d) exp (799,524)", dx, dy);
        end
        tests++;
        if (dhs !== 1'b1 || dvs !== 1'b1) begin
            fails++;
            $display("FAIL reset_sync got hs=%b vs=%b exp 1 1", dhs, dvs);
        end
        tests++;
        if ({dvo, dtk, dls, dfs} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got vo/tk/ls/fs=%b exp 0000", {dvo, dtk, dls, dfs});
        end
        tests++;
        if (px !== 10'd31 || py !== 10'd18 || p_hs !== 1'b0 || p_vs !== 1'b0) begin
            fails++;
            $display("FAIL reset_pol1 got (%0d,%0d) hs=%b vs=%b exp (31,18) 0 0", px, py, p_hs, p_vs);
        end
        en_d = 1'b1; en_s = 1'b1; en_p = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (dtk !== 1'b0 || dx !== 10'd799) begin
            fails++;
            $display("FAIL first_edge got tk=%b x=%0d exp tk=0 x=799", dtk, dx);
        end
        @(negedge clk);
        tests++;
        if (dx !== 10'd0 || dy !== 10'd0 || {dtk, dls, dfs, dvo, dhs} !== 5'b11111) begin
            fails++;
            $display("FAIL second_edge got (%0d,%0d) tk/ls/fs/vo/hs=%b exp (0,0) 11111",
                     dx, dy, {dtk, dls, dfs, dvo, dhs});
        end
    endtask

    task automatic test_hsync_window;
        int fall_x = -1, rise_x = -1, vo_x = -1, bad = 0;
        bit fall_tk = 0, prev_hs, prev_vo;
        prev_hs = dhs; prev_vo = dvo;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (dhs !== prev_hs && !dtk) bad++;
            if (prev_hs && !dhs && fall_x < 0) begin fall_x = dx; fall_tk = dtk; end
            if (!prev_hs && dhs && rise_x < 0) rise_x = dx;
            if (prev_vo && !dvo && vo_x < 0) vo_x = dx;
            prev_hs = dhs; prev_vo = dvo;
            if (rise_x >= 0) break;
        end
        tests++;
        if (fall_x != 656 || !fall_tk) begin
            fails++;
            $display("FAIL hsync_fall got x=%0d tk=%b exp x=656 tk=1", fall_x, fall_tk);
        end
        tests++;
        if (rise_x != 752) begin
            fails++;
            $display("FAIL hsync_rise got x=%0d exp 752", rise_x);
        end
        tests++;
        if (vo_x != 640) begin
            fails++;
            $display("FAIL video_off_x got x=%0d exp 640", vo_x);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hsync_off_tick got %0d changes without pix_tick exp 0", bad);
        end
    endtask

    task automatic test_line_wrap;
        bit found = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (dy == 10'd9 && dx == 10'd799) begin found = 1; break; end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL line_wrap_reach got timeout exp (799,9)");
        end else begin
            found = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (dtk) begin found = 1; break; end
            end
            tests++;
            if (!found || dx !== 10'd0 || dy !== 10'd10 || dls !== 1'b1 || dfs !== 1'b0) begin
                fails++;
                $display("FAIL line_wrap got tick=%b (%0d,%0d) ls=%b fs=%b exp 1 (0,10) 1 0",
                         found, dx, dy, dls, dfs);
            end
        end
    endtask

    task automatic test_frame_small;
        bit found = 0;
        int n = 0, vs_low = 0, vs_bad = 0, vo_bad = 0, lx = -1, ly = -1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (s_fs) begin found = 1; break; end
        end
        if (found) begin
            found = 0;
            for (int i = 0; i < 3000; i++) begin
                if (!s_vs) vs_low++;
                if ((!s_vs) != (sy >= 10'd14 && sy <= 10'd15)) vs_bad++;
                if (s_vo && sy >= 10'd12) vo_bad++;
                lx = sx; ly = sy;
                @(negedge clk);
                n++;
                if (s_fs) begin found = 1; break; end
            end
        end
        tests++;
        if (!found || n != 1216) begin
            fails++;
            $display("FAIL frame_len got found=%b n=%0d exp 1216", found, n);
        end
        tests++;
        if (vs_low != 128 || vs_bad != 0) begin
            fails++;
            $display("FAIL vsync_window got low=%0d bad=%0d exp 128 0", vs_low, vs_bad);
        end
        tests++;
        if (vo_bad != 0) begin
            fails++;
            $display("FAIL vblank_video got %0d exp 0", vo_bad);
        end
        tests++;
        if (lx != 31 || ly != 18 || sx !== 10'd0 || sy !== 10'd0) begin
            fails++;
            $display("FAIL frame_wrap got (%0d,%0d)->(%0d,%0d) exp (31,18)->(0,0)", lx, ly, sx, sy);
        end
    endtask

    task automatic test_enable_low;
        bit found = 0;
        int n = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (s_tk && sx == 10'd10 && sy == 10'd5) begin found = 1; break; end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL enable_reach got timeout exp (10,5)");
        end
        en_s = 1'b0;
        @(negedge clk);
        tests++;
        if (sx !== 10'd31 || sy !== 10'd18 || {s_hs, s_vs, s_vo, s_tk, s_ls, s_fs} !== 6'b110000) begin
            fails++;
            $display("FAIL enable_low got (%0d,%0d) hs/vs/vo/tk/ls/fs=%b exp (31,18) 110000",
                     sx, sy, {s_hs, s_vs, s_vo, s_tk, s_ls, s_fs});
        end
        en_s = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (s_fs) begin found = 1; break; end
        end
        tests++;
        if (!found || n != 2 || sx !== 10'd0 || sy !== 10'd0) begin
            fails++;
            $display("FAIL reenable got fs=%b after %0d edges at (%0d,%0d) exp 2 edges (0,0)",
                     found, n, sx, sy);
        end
    endtask

    task automatic test_div1_pol1;
        bit found = 0;
        int n = 0, tk_bad = 0, hs_bad = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (p_fs) begin found = 1; break; end
        end
        if (found) begin
            found = 0;
            for (int i = 0; i < 1500; i++) begin
                if (p_tk !== 1'b1) tk_bad++;
                if (p_hs !== (px >= 10'd23 && px <= 10'd27)) hs_bad++;
                @(negedge clk);
                n++;
                if (p_fs) begin found = 1; break; end
            end
        end
        tests++;
        if (!found || n != 608) begin
            fails++;
            $display("FAIL div1_frame_len got found=%b n=%0d exp 608", found, n);
        end
        tests++;
        if (tk_bad != 0) begin
            fails++;
            $display("FAIL div1_tick got %0d low cycles exp 0", tk_bad);
        end
        tests++;
        if (hs_bad != 0) begin
            fails++;
            $display("FAIL pol1_hsync got %0d bad cycles exp 0", hs_bad);
        end
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (p_tk && px == 10'd5) begin found = 1; break; end
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (!found || px !== 10'd31 || py !== 10'd18 || {p_hs, p_vs, p_vo, p_tk, p_ls, p_fs} !== 6'b000000
            || dx !== 10'd799) begin
            fails++;
            $display("FAIL async_reset got found=%b (%0d,%0d) hs/vs/vo/tk/ls/fs=%b dx=%0d exp (31,18) 000000 799",
                     found, px, py, {p_hs, p_vs, p_vo, p_tk, p_ls, p_fs}, dx);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tests++;
            if ({dx, dy, dhs, dvs, dvo, dtk, dls, dfs} !==
                {10'(md.x), 10'(md.y), mhs(cd, md), mvs(cd, md), mvo(cd, md), md.tick, md.ls, md.fs}) begin
                fails++;
                $display("FAIL rand_d t=%0t got (%0d,%0d) hs/vs/vo/tk/ls/fs=%b%b%b%b%b%b exp (%0d,%0d) %b%b%b%b%b%b",
                         $time, dx, dy, dhs, dvs, dvo, dtk, dls, dfs, md.x, md.y,
                         mhs(cd, md), mvs(cd, md), mvo(cd, md), md.tick, md.ls, md.fs);
            end
            tests++;
            if ({sx, sy, s_hs, s_vs, s_vo, s_tk, s_ls, s_fs} !==
                {10'(ms.x), 10'(ms.y), mhs(cs, ms), mvs(cs, ms), mvo(cs, ms), ms.tick, ms.ls, ms.fs}) begin
                fails++;
                $display("FAIL rand_s t=%0t got (%0d,%0d) hs/vs/vo/tk/ls/fs=%b%b%b%b%b%b exp (%0d,%0d) %b%b%b%b%b%b",
                         $time, sx, sy, s_hs, s_vs, s_vo, s_tk, s_ls, s_fs, ms.x, ms.y,
                         mhs(cs, ms), mvs(cs, ms), mvo(cs, ms), ms.tick, ms.ls, ms.fs);
            end
            tests++;
            if ({px, py, p_hs, p_vs, p_vo, p_tk, p_ls, p_fs} !==
                {10'(mp.x), 10'(mp.y), mhs(cp, mp), mvs(cp, mp), mvo(cp, mp), mp.tick, mp.ls, mp.fs}) begin
                fails++;
                $display("FAIL rand_p t=%0t got (%0d,%0d) hs/vs/vo/tk/ls/fs=%b%b%b%b%b%b exp (%0d,%0d) %b%b%b%b%b%b",
                         $time, px, py, p_hs, p_vs, p_vo, p_tk, p_ls, p_fs, mp.x, mp.y,
                         mhs(cp, mp), mvs(cp, mp), mvo(cp, mp), mp.tick, mp.ls, mp.fs);
            end
            en_d = ($urandom_range(0, 63) != 0);
            en_s = ($urandom_range(0, 63) != 0);
            en_p = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hsync_window();
        test_line_wrap();
        test_frame_small();
        test_enable_low();
        test_div1_pol1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing controller for the 640x480 VGA display path. Divides the system clock down to a pixel rate and runs the horizontal and vertical scan counters. Drives CounterX/CounterY to the colour generator and field/sprite renderers. Produces registered hsync, vsync, video_on and scan-position strobes, all aligned to the counter values.

## Interface

Parameters:

- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (1..16)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:

- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  run; low returns the block synchronously to the reset state
- CounterX  out  10  current pixel column
- CounterY  out  10  current line
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- video_on  out  1  high when CounterX < H_ACTIVE and CounterY < V_ACTIVE
- pix_tick  out  1  one-clk strobe; counters took a new value this cycle
- line_start  out  1  one-clk strobe coincident with pix_tick when CounterX becomes 0
- frame_start  out  1  one-clk strobe coincident with pix_tick when (CounterX, CounterY) becomes (0, 0)

## Operation

- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK, which is 800 by default. V_TOTAL is formed the same way and is 525 by default. Both totals must be ≤ 1024; violating this is an elaboration error.
- Divider div_cnt counts 0..CLK_DIV-1. When div_cnt = CLK_DIV-1, the next clk edge:
  - advances the scan position;
  - sets pix_tick for one cycle;
  - wraps div_cnt to 0.
- With CLK_DIV = 1, pix_tick stays high continuously while running.
- Advancing the scan position:
  - CounterX increments. At H_TOTAL-1 it wraps to 0 and CounterY increments.
  - At V_TOTAL-1, CounterY wraps to 0.
- Each axis runs a 4-state FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - State changes at the counter boundaries: ACTIVE 0..H_ACTIVE-1, FRONT, SYNC, BACK. Default H: 0–639, 640–655, 656–751, 752–799.
  - The horizontal FSM steps on pix_tick.
  - The vertical FSM steps only on a horizontal wrap.
- hsync = SYNC_POL when the H state is SYNC, otherwise ~SYNC_POL. vsync is derived the same way from the V state.
  - Default active-low hsync: X 656..751.
  - Default active-low vsync: Y 490..491.
- All outputs are registered, computed from next-state values so they change on the same edge as the counters. No output lags CounterX/Y.
- Reset and enable low:
  - CounterX = H_TOTAL-1, CounterY = V_TOTAL-1;
  - both FSMs in BACK;
  - div_cnt = 0;
  - hsync = vsync = ~SYNC_POL;
  - video_on = pix_tick = line_start = frame_start = 0.
  
  The first advance therefore lands on (0, 0) with frame_start asserted.
- Reset or enable low in mid-frame abandons the frame immediately, with no completion of the current line. On restart the block starts a fresh frame.

## Timing

- Latency: CLK_DIV clk edges after reset deassertion (with enable high), the outputs are CounterX = 0, CounterY = 0, video_on = 1, pix_tick = line_start = frame_start = 1.
- Each pixel position is held for exactly CLK_DIV clk cycles.
- Frame length is H_TOTAL·V_TOTAL·CLK_DIV clk cycles, which is 840000 by default.
- Edge ordering:
  - line_start and frame_start never assert without pix_tick;
  - frame_start implies line_start.
- enable is sampled every clk. Deasserting it takes effect on the next edge.

## Structure

- Shared constants.vh holds the default timing constants (H_*/V_*) and the axis state encodings (ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK). It sits alongside the existing FIELD_* bounds so renderers and this block use one source.
- Sub-module vga_axis_timer is parameterised by ACTIVE/FRONT/SYNC/BACK. It is instantiated twice.
  - Inputs: clk, reset, clear, step.
  - Outputs: count[9:0], state, wrap_next, sync, active.
  - The horizontal instance steps on the divider terminal count. The vertical instance steps on the horizontal wrap_next & step.

## Test plan

- Reset, defaults:
  - During reset, CounterX = 799, CounterY = 524, hsync = vsync = 1, video_on = pix_tick = 0.
  - After release, frame_start, line_start and pix_tick rise on the 2nd clk edge with X = Y = 0.
- hsync window:
  - hsync goes low on the pix_tick where X becomes 656 and returns high where X becomes 752.
  - video_on drops where X becomes 640.
- Line and frame wrap:
  - X goes 799 → 0, Y goes 9 → 10 with line_start = 1 and frame_start = 0.
  - At (799, 524) → (0, 0), frame_start = 1.
  - Frame-to-frame spacing is exactly 840000 clks.
- vsync window:
  - vsync is low only for Y = 490..491, i.e. 1600 pixels = 3200 clks per frame.
  - video_on = 0 for every Y ≥ 480.
- enable low at (300, 200):
  - The next edge gives the reset state.
  - After re-enable, frame_start fires CLK_DIV edges later at (0, 0).
- CLK_DIV = 1 with SYNC_POL = 1:
  - pix_tick stays high.
  - hsync is high only for X 656..751.
  - The frame is 420000 clks.
  - Asynchronous reset asserted mid-line clears outputs without waiting for a clk edge.
